uart_tx_cfg: RTL

Runtime-configurable UART transmitter. It is the successor to the fixed 8N1 transmitter and adds a valid/ready byte interface, 5–8 data bits, none/odd/even parity, 1 or 2 stop bits, and a table-selected baud rate. It sits between a byte-producing controller and the serial TX pin. Configuration is captured together with each byte, so frame format can change frame-to-frame without glitches.

---
 rtl/uart_pkg.sv | 47 ++++
 rtl/uart_baud_gen.sv | 38 +++
 rtl/uart_tx_cfg.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART blocks.
//   - baud rate constants and the baud_set -> rate table
//   - parity mode encodings
//   - transmitter state enum
//   - data-length mask helper
package uart_pkg;

  localparam int unsigned BAUD_9600   = 9600;
  localparam int unsigned BAUD_19200  = 19200;
  localparam int unsigned BAUD_38400  = 38400;
  localparam int unsigned BAUD_57600  = 57600;
  localparam int unsigned BAUD_115200 = 115200;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Rate table; the reserved selects 5..7 fall back to the fastest rate.
  function automatic int unsigned baud_rate(input logic [2:0] sel);
    case (sel)
      3'd0:    return BAUD_9600;
      3'd1:    return BAUD_19200;
      3'd2:    return BAUD_38400;
      3'd3:    return BAUD_57600;
      default: return BAUD_115200;
    endcase
  endfunction

  // Keeps only the low 5..8 bits selected by data_bits.
  function automatic logic [7:0] data_mask(input logic [1:0] bits);
    case (bits)
      2'd0:    return 8'h1F;
      2'd1:    return 8'h3F;
      2'd2:    return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : holds the counter at zero
//   bps        : bit period in clock cycles
//   bit_end    : one-cycle pulse on the last cycle of each bit period
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [DIV_W-1:0] bps,
  output logic             bit_end
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             at_end;

  assign at_end  = (cnt_q == bps - DIV_W'(1));
  assign bit_end = at_end && !clear;

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clear || at_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5..8 data bits, none/odd/even
// parity, 1 or 2 stop bits, table-selected baud rate).
//   clk, rst_n   : clock, asynchronous active-low reset
//   baud_set     : rate select (0..3 = 9600..57600, 4..7 = 115200)
//   data_bits    : 0..3 = 5..8 data bits
//   parity_mode  : 0/3 none, 1 odd, 2 even
//   stop2        : two stop bits when set
//   tx_data      : byte to send, LSB first
//   tx_valid     : byte and config are valid
//   tx_ready     : transmitter is idle and will accept
//   tx           : registered serial line, idle high
//   tx_busy      : frame in progress
//   tx_done      : high on the last cycle of the final stop bit
//
// Handshake: a byte is accepted on any cycle where tx_valid && tx_ready.
// tx_data and all config inputs are sampled on that cycle only; they may
// change freely afterwards without affecting the frame in flight.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int DIV_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] baud_set,
  input  logic [1:0] data_bits,
  input  logic [1:0] parity_mode,
  input  logic       stop2,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [DIV_W-1:0] BPS_0 = DIV_W'(CLK_FREQ / baud_rate(3'd0));
  localparam logic [DIV_W-1:0] BPS_1 = DIV_W'(CLK_FREQ / baud_rate(3'd1));
  localparam logic [DIV_W-1:0] BPS_2 = DIV_W'(CLK_FREQ / baud_rate(3'd2));
  localparam logic [DIV_W-1:0] BPS_3 = DIV_W'(CLK_FREQ / baud_rate(3'd3));
  localparam logic [DIV_W-1:0] BPS_4 = DIV_W'(CLK_FREQ / baud_rate(3'd4));

  tx_state_e        state_q;
  logic             tx_q;
  logic [7:0]       shift_q;
  logic [3:0]       bit_cnt_q;
  logic [3:0]       last_idx_q;
  logic             par_en_q;
  logic             par_bit_q;
  logic             stop2_q;
  logic [DIV_W-1:0] bps_q;

  logic [DIV_W-1:0] bps_sel;
  logic [7:0]       masked_data;
  logic             accept;
  logic             bit_end;
  logic             last_stop;

  always_comb begin
    case (baud_set)
      3'd0:    bps_sel = BPS_0;
      3'd1:    bps_sel = BPS_1;
      3'd2:    bps_sel = BPS_2;
      3'd3:    bps_sel = BPS_3;
      default: bps_sel = BPS_4;
    endcase
  end

  assign masked_data = tx_data & data_mask(data_bits);
  assign accept      = tx_valid && (state_q == ST_IDLE);
  assign last_stop   = (bit_cnt_q == {3'b000, stop2_q});

  assign tx       = tx_q;
  assign tx_ready = (state_q == ST_IDLE);
  assign tx_busy  = (state_q != ST_IDLE);
  assign tx_done  = (state_q == ST_STOP) && bit_end && last_stop;

  // Counter sits at zero while idle, so the start bit gets a full period
  // measured from the accept edge.
  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == ST_IDLE),
    .bps     (bps_q),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      last_idx_q <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      bps_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (accept) begin
            shift_q    <= masked_data;
            last_idx_q <= {2'b00, data_bits} + 4'd4;
            par_en_q   <= (parity_mode == PAR_ODD) || (parity_mode == PAR_EVEN);
            // Masked bits are zero, so XOR over all 8 equals XOR over N.
            par_bit_q  <= (^masked_data) ^ (parity_mode == PAR_ODD);
            stop2_q    <= stop2;
            bps_q      <= bps_sel;
            bit_cnt_q  <= '0;
            tx_q       <= 1'b0;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_cnt_q == last_idx_q) begin
              bit_cnt_q <= '0;
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= ST_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            tx_q      <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              bit_cnt_q <= '0;
              state_q   <= ST_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
